// File: rtl/uxn_stack_unit.sv
// uxn_stack_unit
//   Multi-stack byte storage for the Uxn core. NUM_STACKS stacks share one
//   dual-port RAM; each stack owns 2**PTR_W cells addressed as {sel, ptr}, with
//   its own wrapping pointer. Commands: PUSH / POP / PEEK / SET_SP, byte or
//   big-endian short. A short uses RAM port A for the high cell and port B for
//   the low cell in the same cycle.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/op/short/sel/data   command handshake and payload
//   rd_valid/ready/data       POP/PEEK result handshake (byte zero-extended)
//   sp_out                    all pointers, stack k at [k*PTR_W +: PTR_W]
//   err_ovf, err_unf, err_clr sticky over/underflow flags and their clear
module uxn_stack_unit #(
  parameter int DATA_W     = 8,
  parameter int PTR_W      = 8,
  parameter int NUM_STACKS = 2,
  parameter int SEL_W      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic                        cmd_short,
  input  logic [SEL_W-1:0]            cmd_sel,
  input  logic [2*DATA_W-1:0]         cmd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [2*DATA_W-1:0]         rd_data,
  output logic [NUM_STACKS*PTR_W-1:0] sp_out,
  output logic                        err_ovf,
  output logic                        err_unf,
  input  logic                        err_clr
);

  localparam int AW = SEL_W + PTR_W;
  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_PEEK = 2'd2;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   PTR_CAP = {1'b1, {PTR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_HOLD = 2'd2} state_t;

  logic [DATA_W-1:0] mem [NUM_STACKS << PTR_W];

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    sp_q [NUM_STACKS];
  logic [PTR_W-1:0]    sp_d [NUM_STACKS];
  logic                cmd_ready_q, cmd_ready_d;
  logic                rd_valid_q, rd_valid_d;
  logic [2*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_unf_q, err_unf_d;
  logic [AW-1:0]       raddr_a_q, raddr_a_d;
  logic [AW-1:0]       raddr_b_q, raddr_b_d;
  logic                rshort_q, rshort_d;
  logic [DATA_W-1:0]   ram_a_q, ram_b_q;

  logic                accept_s, sel_ok_s;
  logic [PTR_W-1:0]    cur_sp_s, base_s;
  logic [PTR_W:0]      n_s;
  logic [AW-1:0]       addr_a_s, addr_b_s;
  logic                we_a_s, we_b_s;
  logic [DATA_W-1:0]   wd_a_s, wd_b_s;

  // Command decode: cell count, pointer arithmetic and both port addresses.
  always_comb begin
    accept_s = cmd_valid & cmd_ready_q;
    sel_ok_s = (int'(cmd_sel) < NUM_STACKS);
    cur_sp_s = sp_q[cmd_sel];
    n_s      = {{(PTR_W-1){1'b0}}, cmd_short, ~cmd_short};
    // PUSH writes upward from sp; POP/PEEK read upward from sp-n.
    if (cmd_op == OP_PUSH) begin
      base_s = cur_sp_s;
    end else begin
      base_s = cur_sp_s - n_s[PTR_W-1:0];
    end
    addr_a_s = {cmd_sel, base_s};
    addr_b_s = {cmd_sel, base_s + PTR_ONE};
    wd_a_s   = cmd_short ? cmd_data[2*DATA_W-1:DATA_W] : cmd_data[DATA_W-1:0];
    wd_b_s   = cmd_data[DATA_W-1:0];
  end

  // Next-state, pointer, flag and response logic.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    rd_valid_d = rd_valid_q;
    rd_data_d = rd_data_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    rshort_d  = rshort_q;
    // A new error in the same cycle as err_clr overrides the clear below.
    err_ovf_d = err_ovf_q & ~err_clr;
    err_unf_d = err_unf_q & ~err_clr;
    we_a_s    = 1'b0;
    we_b_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_PUSH: begin
              we_a_s = sel_ok_s;
              we_b_s = sel_ok_s & cmd_short;
              if (sel_ok_s) begin
                sp_d[cmd_sel] = cur_sp_s + n_s[PTR_W-1:0];
              end else begin
                sp_d[cmd_sel] = cur_sp_s;
              end
              if (({1'b0, cur_sp_s} + n_s) > PTR_CAP) begin
                err_ovf_d = 1'b1;
              end else begin
                err_ovf_d = err_ovf_d;
              end
            end
            OP_POP, OP_PEEK: begin
              raddr_a_d = addr_a_s;
              raddr_b_d = addr_b_s;
              rshort_d  = cmd_short;
              state_d   = S_READ;
              if ((cmd_op == OP_POP) && sel_ok_s) begin
                sp_d[cmd_sel] = base_s;
              end else begin
                sp_d[cmd_sel] = cur_sp_s;
              end
              if ({1'b0, cur_sp_s} < n_s) begin
                err_unf_d = 1'b1;
              end else begin
                err_unf_d = err_unf_d;
              end
            end
            default: begin
              if (sel_ok_s) begin
                sp_d[cmd_sel] = cmd_data[PTR_W-1:0];
              end else begin
                sp_d[cmd_sel] = cur_sp_s;
              end
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // First HOLD cycle registers the RAM q; afterwards wait for the taker.
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rshort_q ? {ram_a_q, ram_b_q} : {{DATA_W{1'b0}}, ram_a_q};
        end else if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < NUM_STACKS; k++) sp_q[k] <= '0;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      raddr_a_q   <= '0;
      raddr_b_q   <= '0;
      rshort_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      raddr_a_q   <= raddr_a_d;
      raddr_b_q   <= raddr_b_d;
      rshort_q    <= rshort_d;
    end
  end

  // Dual-port RAM: contents survive reset; both ports read during READ.
  always_ff @(posedge clk) begin
    if (we_a_s) mem[addr_a_s] <= wd_a_s;
    if (we_b_s) mem[addr_b_s] <= wd_b_s;
    if (state_q == S_READ) begin
      ram_a_q <= mem[raddr_a_q];
      ram_b_q <= mem[raddr_b_q];
    end
  end

  // Pack the pointers for the system device.
  always_comb begin
    sp_out = '0;
    for (int k = 0; k < NUM_STACKS; k++) sp_out[k*PTR_W +: PTR_W] = sp_q[k];
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule
